// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helper for the sync_fifo block.
package sync_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  // Address width for a power-of-two depth; never below 1 so slices stay legal.
  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port register file for sync_fifo. Read port is registered by default,
// combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = addr_width(DEPTH_DEF)
) (
  input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                  rst_n,
  input  logic                  rd_en,
`endif
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the pointers alone define which words are valid,
  // and leaving it out keeps the array mappable to plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];
`else
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, flags and accept logic around sync_fifo_ram.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through output.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,   // active-high despite the name
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  en_wr,
  input  logic                  en_rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Extra MSB distinguishes full from empty when the address bits coincide.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign wr_acc = en_wr & ~full;
  assign rd_acc = en_rd & ~empty;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .rst_n   (rst_n),
    .rd_en   (rd_acc),
`endif
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo in its default (registered-read) build.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       en_wr;
  logic       en_rd;
  logic [7:0] data_out;
  logic       empty;
  logic       full;

  int tests_run = 0;
  int tests_failed = 0;

  sync_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .en_wr    (en_wr),
    .en_rd    (en_rd),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] exp_data,
                             input logic exp_empty, input logic exp_full);
    check({tag, ".data"},  32'(data_out), 32'(exp_data));
    check({tag, ".empty"}, 32'(empty),    32'(exp_empty));
    check({tag, ".full"},  32'(full),     32'(exp_full));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; en_wr = 1'b0; en_rd = 1'b0; data_in = 8'h00;

    // Reset held for two cycles, then released.
    tick(); tick();
    check_state("reset", 8'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_state("post_reset", 8'h00, 1'b1, 1'b0);

    // Fill with 00..0F.
    for (int i = 0; i < 16; i++) begin
      en_wr = 1'b1; data_in = 8'(i);
      tick();
      if (i == 0) check("fill.empty_first", 32'(empty), 32'd0);
      check("fill.full", 32'(full), 32'(i == 15));
    end
    // 17th write of AA must be dropped.
    data_in = 8'hAA;
    tick();
    check_state("overflow", 8'h00, 1'b0, 1'b1);
    en_wr = 1'b0;

    // Drain 17 reads: 00..0F, then data_out holds 0F.
    en_rd = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      check_state("drain", (i < 16) ? 8'(i) : 8'h0F, i >= 15, 1'b0);
    end
    en_rd = 1'b0;

    // Concurrent: 5 entries, then 20 cycles of simultaneous read/write across the wrap.
    for (int i = 0; i < 5; i++) begin
      en_wr = 1'b1; data_in = 8'h20 + 8'(i);
      tick();
    end
    en_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'h25 + 8'(i);
      tick();
      check_state("concurrent", 8'h20 + 8'(i), 1'b0, 1'b0);
    end
    en_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("conc_drain", 8'h34 + 8'(i), i == 4, 1'b0);
    end
    en_rd = 1'b0;

    // Full with both enables: one read, write of BB dropped.
    for (int i = 0; i < 16; i++) begin
      en_wr = 1'b1; data_in = 8'h40 + 8'(i);
      tick();
    end
    check("full_setup", 32'(full), 32'd1);
    en_rd = 1'b1; data_in = 8'hBB;
    tick();
    check_state("full_both", 8'h40, 1'b0, 1'b0);
    en_wr = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check_state("full_drain", 8'h40 + 8'(i), i == 15, 1'b0);
    end
    tick();
    check_state("underflow", 8'h4F, 1'b1, 1'b0);

    // Empty with both enables: write accepted, data_out unchanged.
    en_wr = 1'b1; data_in = 8'hCC;
    tick();
    check_state("empty_both", 8'h4F, 1'b0, 1'b0);
    en_wr = 1'b0;
    tick();
    check_state("empty_both_rd", 8'hCC, 1'b1, 1'b0);
    en_rd = 1'b0;

    // Reset mid-stream with 7 entries held: asynchronous, effective before any edge.
    for (int i = 0; i < 7; i++) begin
      en_wr = 1'b1; data_in = 8'h50 + 8'(i);
      tick();
    end
    en_wr = 1'b0;
    check("pre_reset.empty", 32'(empty), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check_state("async_reset", 8'h00, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check_state("after_reset", 8'h00, 1'b1, 1'b0);

    // Fresh writes are the first words read back.
    for (int i = 0; i < 2; i++) begin
      en_wr = 1'b1; data_in = 8'h60 + 8'(i);
      tick();
    end
    en_wr = 1'b0; en_rd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_state("restart", 8'h60 + 8'(i), i == 1, 1'b0);
    end
    en_rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
